memory_bus_master: RTL and testbench
====================================

Name: memory_bus_master

Overview:
- Upstream controller for the banked register Memory (Select / DataBus / RW interface).
- Accepts single-word read/write requests over a valid/ready handshake and sequences the Memory's two-phase protocol:
  - address phase: Memory latches Select on the clock edge;
  - data phase: Memory drives, or samples, the shared tristate DataBus.
- Returns read data, or a write acknowledge, through a one-entry response buffer.
- Sits between the machine's control unit and the Memory instance, and is the only other driver of DataBus.

Parameters:
- N, 8, data word width; must equal the Memory's N.
- M, 2, address width; must equal the Memory's M. The Memory has 2^M cells.

Ports:
- Clock  in  1  posedge clock, shared with the Memory.
- ResetN  in  1  reset; synchronous and active-low, sampled on posedge Clock.
- ReqValid  in  1  request present.
- ReqReady  out  1  request accepted when ReqValid && ReqReady at posedge.
- ReqWrite  in  1  1 = write, 0 = read.
- ReqAddr  in  M  target cell.
- ReqData  in  N  write data; ignored for reads.
- RespValid  out  1  response buffer full.
- RespReady  in  1  consumer takes the response when RespValid && RespReady at posedge.
- RespWrite  out  1  echo of the completed request type.
- RespData  out  N  read data, or the written word for writes.
- MemSelect  out  M  to Memory Select.
- MemRW  out  1  to Memory RW; 0 = read, 1 = write.
- MemData  inout  N  to Memory DataBus.

Behaviour:
- Reset (ResetN=0 at posedge):
  - State=IDLE.
  - MemSelect=0, MemRW=0, MemData=Z.
  - RespValid=0, RespWrite=0, RespData=0.
  - Any in-flight request is dropped; no Memory write may occur at that edge.
- States:
  - IDLE: MemRW=0, MemData=Z, MemSelect holds its last value.
  - ADDR: MemSelect=latched address, MemRW=0, MemData=Z.
  - RDATA: MemSelect unchanged, MemRW=0, MemData=Z.
  - WDATA: MemSelect unchanged, MemRW=1, MemData=latched write data.
- ReqReady = (State==IDLE) && (!RespValid || RespReady). This is combinational; a response drain and a new accept may happen in the same cycle.
- Accept at edge T: latch ReqAddr, ReqWrite and ReqData; go to ADDR. MemSelect updates registered, so it is valid during cycle T+1.
- ADDR (T+1): the Memory latches MemSelect at the closing edge. Next state is WDATA if ReqWrite, else RDATA.
- RDATA (T+2): the Memory drives MemData. At the closing edge:
  - RespData <= MemData, RespWrite <= 0, RespValid <= 1;
  - go to IDLE.
- WDATA (T+2): the Memory writes MemData into the selected cell at the closing edge. At that same edge:
  - RespData <= write data, RespWrite <= 1, RespValid <= 1;
  - go to IDLE.
- Latency and throughput:
  - Accept-to-RespValid is 3 cycles.
  - Maximum throughput is one request per 3 cycles with RespReady held high.
- MemRW must be 0 in every state except WDATA. Otherwise the Memory would write a floating bus into the previously addressed cell.
- MemSelect must be stable across ADDR and the data phase.
- MemData is driven only while MemRW=1. No cycle may have both MemRW=0 and MemData driven (no bus contention).
- RespValid holds, with RespData and RespWrite stable, until consumed.
  - Consume without a new response: RespValid <= 0.
  - Consume while RDATA/WDATA completes: this cannot happen, because the buffer must be empty for the request to have been accepted.
- ReqValid dropping mid-transaction has no effect, since request fields are latched.
- ReqAddr covers the full 2^M range; no out-of-range case exists.

Decomposition:
- Shared package memory_bus_pkg:
  - state enum {IDLE, ADDR, RDATA, WDATA};
  - constants RW_READ=0 and RW_WRITE=1.
- One sub-module, bus_tristate_driver (N-bit enable/out/in tristate pad), so the Memory-side bus ownership is isolated and reusable by other bus masters.

Test Plan:
- Reset: hold ResetN=0 for 2 cycles mid-WDATA -> MemRW=0, MemData=Z, RespValid=0 next cycle; cell contents are unchanged, checked by a subsequent read.
- Write then read: write 8'hA5 to address 2, then read address 2 -> write response RespWrite=1, RespData=A5 at accept+3; read response RespData=A5 at its accept+3.
- All cells: write 8'h11, 22, 33, 44 to addresses 0..3, then read 3,2,1,0 -> 44, 33, 22, 11. MemRW is high only in WDATA cycles.
- Back-pressure: RespReady=0 after the first response -> ReqReady stays 0, the second request waits, the first RespData is held stable. Raising RespReady drains the response and accepts the next request in the same cycle.
- Bus contention: monitor every cycle -> never (MemRW=0 && master driving MemData); MemSelect is constant from ADDR through the data phase.
- Back-to-back: ReqValid held with RespReady=1 and 6 alternating read/write requests -> one accept every 3 cycles and all data correct.

Source files
------------

// File: rtl/memory_bus_pkg.sv
// Shared types for the Memory bus master: transaction FSM states and RW encodings.
package memory_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    RDATA = 2'd2,
    WDATA = 2'd3
  } state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/bus_tristate_driver.sv
// N-bit tristate pad: drives the shared bus only while enabled, always returns the bus value.
module bus_tristate_driver #(
  parameter int N = 8
) (
  input  logic         en_i,
  input  logic [N-1:0] data_i,
  output logic [N-1:0] data_o,
  inout  wire  [N-1:0] pad_io
);

  assign pad_io = en_i ? data_i : {N{1'bz}};
  assign data_o = pad_io;

endmodule

// File: rtl/memory_bus_master.sv
// Single-word request/response front end that sequences the Memory's address/data phases
// and owns the master side of the shared DataBus.
module memory_bus_master
  import memory_bus_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 2
) (
  input  logic         Clock,
  input  logic         ResetN,
  input  logic         ReqValid,
  output logic         ReqReady,
  input  logic         ReqWrite,
  input  logic [M-1:0] ReqAddr,
  input  logic [N-1:0] ReqData,
  output logic         RespValid,
  input  logic         RespReady,
  output logic         RespWrite,
  output logic [N-1:0] RespData,
  output logic [M-1:0] MemSelect,
  output logic         MemRW,
  inout  wire  [N-1:0] MemData
);

  state_e         state_q, state_d;
  logic [M-1:0]   addr_q, addr_d;
  logic           write_q, write_d;
  logic [N-1:0]   wdata_q, wdata_d;
  logic           resp_valid_q, resp_valid_d;
  logic           resp_write_q, resp_write_d;
  logic [N-1:0]   resp_data_q, resp_data_d;
  logic [N-1:0]   bus_in;
  logic           bus_drive;

  assign ReqReady = (state_q == IDLE) && (!resp_valid_q || RespReady);

  // Gated by ResetN so a reset landing in WDATA cannot let the Memory commit that edge.
  assign bus_drive = (state_q == WDATA) && ResetN;
  assign MemRW     = bus_drive ? RW_WRITE : RW_READ;
  assign MemSelect = addr_q;
  assign RespValid = resp_valid_q;
  assign RespWrite = resp_write_q;
  assign RespData  = resp_data_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_write_d = resp_write_q;
    resp_data_d  = resp_data_q;

    if (resp_valid_q && RespReady) begin
      resp_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ReqValid && ReqReady) begin
          addr_d  = ReqAddr;
          write_d = ReqWrite;
          wdata_d = ReqData;
          state_d = ADDR;
        end
      end
      ADDR: begin
        state_d = (write_q == RW_WRITE) ? WDATA : RDATA;
      end
      RDATA: begin
        resp_data_d  = bus_in;
        resp_write_d = RW_READ;
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      WDATA: begin
        resp_data_d  = wdata_q;
        resp_write_d = RW_WRITE;
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      write_q      <= RW_READ;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_write_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_write_q <= resp_write_d;
      resp_data_q  <= resp_data_d;
    end
  end

  bus_tristate_driver #(.N(N)) u_drv (
    .en_i   (bus_drive),
    .data_i (wdata_q),
    .data_o (bus_in),
    .pad_io (MemData)
  );

endmodule

// File: tb/tb_memory_bus_master.sv
// Directed bench for memory_bus_master against a behavioural banked-register Memory.
module tb_memory_bus_master;

  logic       Clock = 1'b0;
  logic       ResetN = 1'b0;
  logic       ReqValid = 1'b0;
  logic       ReqWrite = 1'b0;
  logic [1:0] ReqAddr = 2'd0;
  logic [7:0] ReqData = 8'h00;
  logic       RespReady = 1'b1;
  logic       ReqReady;
  logic       RespValid;
  logic       RespWrite;
  logic [7:0] RespData;
  logic [1:0] MemSelect;
  logic       MemRW;
  wire  [7:0] MemData;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  memory_bus_master #(.N(8), .M(2)) dut (
    .Clock     (Clock),
    .ResetN    (ResetN),
    .ReqValid  (ReqValid),
    .ReqReady  (ReqReady),
    .ReqWrite  (ReqWrite),
    .ReqAddr   (ReqAddr),
    .ReqData   (ReqData),
    .RespValid (RespValid),
    .RespReady (RespReady),
    .RespWrite (RespWrite),
    .RespData  (RespData),
    .MemSelect (MemSelect),
    .MemRW     (MemRW),
    .MemData   (MemData)
  );

  // Memory model: Select latched every edge, drives the bus while RW=0, writes on RW=1.
  logic [7:0] cells [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [1:0] mem_sel_q = 2'd0;
  always @(posedge Clock) begin
    mem_sel_q <= MemSelect;
    if (MemRW) cells[mem_sel_q] <= MemData;
  end
  assign MemData = MemRW ? 8'bzzzzzzzz : cells[mem_sel_q];

  typedef struct {
    int         cyc;
    logic       w;
    logic [7:0] d;
  } resp_t;
  resp_t resp_q[$];

  always @(negedge Clock) begin
    if (ResetN && RespValid && RespReady) begin
      resp_q.push_back('{cyc, RespWrite, RespData});
      $display("resp cyc=%0d write=%0b data=%h", cyc, RespWrite, RespData);
    end
  end

  // Bus-protocol monitor: phases are derived from the accept handshake, not from DUT state.
  logic       mon_acc = 1'b0;
  logic       mon_wr = 1'b0;
  logic       mon_addr_ph = 1'b0;
  logic       mon_addr_wr = 1'b0;
  logic [1:0] mon_sel = 2'd0;
  int         mon_viol = 0;
  int         mon_addr_cnt = 0;
  int         mon_rw_cnt = 0;
  always @(negedge Clock) begin
    if (!ResetN) begin
      mon_acc     <= 1'b0;
      mon_wr      <= 1'b0;
      mon_addr_ph <= 1'b0;
      mon_addr_wr <= 1'b0;
    end else begin
      mon_acc     <= ReqValid && ReqReady;
      mon_wr      <= ReqWrite;
      mon_addr_ph <= mon_acc;
      mon_addr_wr <= mon_wr;
      if (ReqValid && ReqReady) mon_sel <= ReqAddr;
      if (mon_acc) mon_addr_cnt <= mon_addr_cnt + 1;
      if ((!MemRW && dut.u_drv.en_i) ||
          ((mon_acc || mon_addr_ph) && (MemSelect !== mon_sel)) ||
          (MemRW !== (mon_addr_ph && mon_addr_wr)))
        mon_viol <= mon_viol + 1;
    end
    if (MemRW) mon_rw_cnt <= mon_rw_cnt + 1;
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the accept.
  task automatic send_req(input logic wr, input logic [1:0] a, input logic [7:0] d,
                          input bit hold, output int acc);
    bit ok;
    ReqValid = 1'b1;
    ReqWrite = wr;
    ReqAddr  = a;
    ReqData  = d;
    ok  = 1'b0;
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (ReqReady) begin
        acc = cyc;
        ok  = 1'b1;
      end
      @(posedge Clock); #1;
      if (ok) break;
    end
    if (!hold) ReqValid = 1'b0;
  endtask

  task automatic get_resp(output int rc, output logic w, output logic [7:0] d);
    resp_t r;
    rc = -100;
    w  = 1'bx;
    d  = 8'hxx;
    for (int i = 0; i < 40; i++) begin
      if (resp_q.size() > 0) begin
        r  = resp_q.pop_front();
        rc = r.cyc;
        w  = r.w;
        d  = r.d;
        break;
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_reset;
    ResetN = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    n_checks++;
    if ({MemRW, dut.u_drv.en_i, RespValid, RespWrite} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rw=%b drv=%b rv=%b rw_echo=%b, expected all 0",
               MemRW, dut.u_drv.en_i, RespValid, RespWrite);
    end
    n_checks++;
    if ({MemSelect, RespData} !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_data: got sel=%h data=%h, expected 0 and 00", MemSelect, RespData);
    end
    ResetN = 1'b1;
    @(posedge Clock); #1;
    n_checks++;
    if (ReqReady !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, expected 1", ReqReady);
    end
  endtask

  task automatic test_write_then_read;
    int acc, rc;
    logic w;
    logic [7:0] d;
    RespReady = 1'b1;
    send_req(1'b1, 2'd2, 8'hA5, 1'b0, acc);
    get_resp(rc, w, d);
    n_checks++;
    if ({w, d} !== {1'b1, 8'hA5}) begin
      n_fail++;
      $display("FAIL wr_resp: got w=%b d=%h, expected w=1 d=a5", w, d);
    end
    n_checks++;
    if (rc !== acc + 3) begin
      n_fail++;
      $display("FAIL wr_latency: got %0d, expected 3", rc - acc);
    end
    send_req(1'b0, 2'd2, 8'h00, 1'b0, acc);
    get_resp(rc, w, d);
    n_checks++;
    if ({w, d} !== {1'b0, 8'hA5}) begin
      n_fail++;
      $display("FAIL rd_resp: got w=%b d=%h, expected w=0 d=a5", w, d);
    end
    n_checks++;
    if (rc !== acc + 3) begin
      n_fail++;
      $display("FAIL rd_latency: got %0d, expected 3", rc - acc);
    end
  endtask

  task automatic test_all_cells;
    logic [7:0] vals [4];
    int acc, rc;
    logic w;
    logic [7:0] d;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      send_req(1'b1, 2'(i), vals[i], 1'b0, acc);
      get_resp(rc, w, d);
      n_checks++;
      if ({w, d} !== {1'b1, vals[i]}) begin
        n_fail++;
        $display("FAIL cells_wr[%0d]: got w=%b d=%h, expected w=1 d=%h", i, w, d, vals[i]);
      end
    end
    for (int i = 3; i >= 0; i--) begin
      send_req(1'b0, 2'(i), 8'h00, 1'b0, acc);
      get_resp(rc, w, d);
      n_checks++;
      if ({w, d} !== {1'b0, vals[i]}) begin
        n_fail++;
        $display("FAIL cells_rd[%0d]: got w=%b d=%h, expected w=0 d=%h", i, w, d, vals[i]);
      end
    end
  endtask

  task automatic test_reset_mid_write;
    int acc, rc;
    logic w;
    logic [7:0] d;
    send_req(1'b1, 2'd1, 8'hFF, 1'b0, acc);
    @(posedge Clock); #1;
    n_checks++;
    if (MemRW !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_wdata: got rw=%b, expected 1", MemRW);
    end
    ResetN = 1'b0;
    #1;
    n_checks++;
    if ({MemRW, dut.u_drv.en_i} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_gate: got rw=%b drv=%b, expected 0 0", MemRW, dut.u_drv.en_i);
    end
    @(posedge Clock); #1;
    n_checks++;
    if ({MemRW, dut.u_drv.en_i, RespValid, MemSelect} !== 5'b00000) begin
      n_fail++;
      $display("FAIL midrst_state: got rw=%b drv=%b rv=%b sel=%h, expected all 0",
               MemRW, dut.u_drv.en_i, RespValid, MemSelect);
    end
    @(posedge Clock); #1;
    ResetN = 1'b1;
    @(posedge Clock); #1;
    send_req(1'b0, 2'd1, 8'h00, 1'b0, acc);
    get_resp(rc, w, d);
    n_checks++;
    if ({w, d} !== {1'b0, 8'h22}) begin
      n_fail++;
      $display("FAIL midrst_cell: got w=%b d=%h, expected w=0 d=22", w, d);
    end
  endtask

  task automatic test_back_pressure;
    int acc, acc2, rc;
    logic w;
    logic [7:0] d;
    RespReady = 1'b0;
    send_req(1'b0, 2'd3, 8'h00, 1'b0, acc);
    rc = -100;
    for (int i = 0; i < 10; i++) begin
      if (RespValid) begin
        rc = cyc;
        break;
      end
      @(posedge Clock); #1;
    end
    n_checks++;
    if ({rc == acc + 3, RespWrite, RespData} !== {1'b1, 1'b0, 8'h44}) begin
      n_fail++;
      $display("FAIL bp_first: got lat=%0d w=%b d=%h, expected lat=3 w=0 d=44",
               rc - acc, RespWrite, RespData);
    end
    ReqValid = 1'b1;
    ReqWrite = 1'b1;
    ReqAddr  = 2'd0;
    ReqData  = 8'h77;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if ({ReqReady, RespValid, RespData} !== {1'b0, 1'b1, 8'h44}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got ready=%b rv=%b d=%h, expected ready=0 rv=1 d=44",
                 i, ReqReady, RespValid, RespData);
      end
      @(posedge Clock); #1;
    end
    RespReady = 1'b1;
    #1;
    n_checks++;
    if (ReqReady !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drain_ready: got %b, expected 1", ReqReady);
    end
    acc2 = cyc;
    @(posedge Clock); #1;
    ReqValid = 1'b0;
    n_checks++;
    if ({RespValid, MemSelect} !== {1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL bp_drain_accept: got rv=%b sel=%h, expected rv=0 sel=0", RespValid, MemSelect);
    end
    get_resp(rc, w, d);
    n_checks++;
    if ({w, d} !== {1'b0, 8'h44}) begin
      n_fail++;
      $display("FAIL bp_popped_first: got w=%b d=%h, expected w=0 d=44", w, d);
    end
    get_resp(rc, w, d);
    n_checks++;
    if ({w, d, rc == acc2 + 3} !== {1'b1, 8'h77, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_second: got w=%b d=%h lat=%0d, expected w=1 d=77 lat=3", w, d, rc - acc2);
    end
  endtask

  task automatic test_back_to_back;
    logic       w_v [6];
    logic [1:0] a_v [6];
    logic [7:0] d_v [6];
    logic [7:0] e_v [6];
    int         acc [6];
    int         rc;
    logic       w;
    logic [7:0] d;
    w_v[0] = 1'b1; a_v[0] = 2'd1; d_v[0] = 8'hC3; e_v[0] = 8'hC3;
    w_v[1] = 1'b0; a_v[1] = 2'd1; d_v[1] = 8'h00; e_v[1] = 8'hC3;
    w_v[2] = 1'b1; a_v[2] = 2'd2; d_v[2] = 8'h96; e_v[2] = 8'h96;
    w_v[3] = 1'b0; a_v[3] = 2'd2; d_v[3] = 8'h00; e_v[3] = 8'h96;
    w_v[4] = 1'b1; a_v[4] = 2'd3; d_v[4] = 8'h0F; e_v[4] = 8'h0F;
    w_v[5] = 1'b0; a_v[5] = 2'd0; d_v[5] = 8'h00; e_v[5] = 8'h77;
    RespReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_req(w_v[i], a_v[i], d_v[i], (i < 5), acc[i]);
    end
    for (int i = 0; i < 6; i++) begin
      get_resp(rc, w, d);
      n_checks++;
      if ({w, d} !== {w_v[i], e_v[i]}) begin
        n_fail++;
        $display("FAIL b2b_data[%0d]: got w=%b d=%h, expected w=%b d=%h", i, w, d, w_v[i], e_v[i]);
      end
      n_checks++;
      if (rc !== acc[i] + 3) begin
        n_fail++;
        $display("FAIL b2b_latency[%0d]: got %0d, expected 3", i, rc - acc[i]);
      end
      if (i > 0) begin
        n_checks++;
        if (acc[i] - acc[i-1] !== 3) begin
          n_fail++;
          $display("FAIL b2b_spacing[%0d]: got %0d, expected 3", i, acc[i] - acc[i-1]);
        end
      end
    end
  endtask

  task automatic test_bus_contention;
    repeat (2) @(posedge Clock);
    #1;
    n_checks++;
    if (mon_viol !== 0) begin
      n_fail++;
      $display("FAIL bus_protocol: got %0d violating cycles, expected 0", mon_viol);
    end
    n_checks++;
    if (mon_addr_cnt !== 20) begin
      n_fail++;
      $display("FAIL bus_addr_phases: got %0d, expected 20", mon_addr_cnt);
    end
    n_checks++;
    if (mon_rw_cnt !== 9) begin
      n_fail++;
      $display("FAIL bus_write_cycles: got %0d, expected 9", mon_rw_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_write_then_read;
    test_all_cells;
    test_reset_mid_write;
    test_back_pressure;
    test_back_to_back;
    test_bus_contention;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
